writeback_broadcast: RTL

Collects completed results from the ALU and memory execution ports, buffers them in a small FIFO, and drives the single-result-per-cycle broadcast bus that the issue queue snoops to wake waiting operands. It also owns the 64-entry physical-register ready vector that the issue queue reads at enqueue time. It sits between the execution units and the issue queue/ROB, at the producer end of the `exe_broadcast*` / `busy` interface.

---
 rtl/writeback_broadcast.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/writeback_broadcast.sv
// Writeback collector: merges ALU/MEM results into a FIFO, broadcasts one per cycle, owns the ready vector.
// Optional WB_BYPASS_EN: a lone result arriving at an empty, unstalled FIFO is broadcast directly (latency 1).
module writeback_broadcast #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        alu_valid,
  input  logic [5:0]  alu_map,
  input  logic [31:0] alu_val,
  input  logic [31:0] alu_instr_num,
  input  logic        mem_valid,
  input  logic [5:0]  mem_map,
  input  logic [31:0] mem_val,
  input  logic [31:0] mem_instr_num,
  input  logic        rename_alloc,
  input  logic [5:0]  rename_alloc_map,
  output logic        exe_broadcast,
  output logic [5:0]  exe_broadcast_map,
  output logic [31:0] exe_broadcast_val,
  output logic [31:0] broadcast_instr_num,
  output logic [63:0] busy,
  output logic        wb_full,
  output logic        wb_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [5:0]  map;
    logic [31:0] val;
    logic [31:0] tag;
  } wb_entry_t;

  wb_entry_t         fifo_q [DEPTH];
  wb_entry_t         fifo_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  wb_entry_t         bc_q, bc_d;
  logic              bc_vld_q, bc_vld_d;
  logic [63:0]       busy_q, busy_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;

  wb_entry_t         alu_entry, mem_entry, head;
  logic              alu_ok, mem_ok, pop, byp, mem_acc, alu_acc, drop;
  logic [CW:0]       occ;

  assign alu_entry = '{map: alu_map, val: alu_val, tag: alu_instr_num};
  assign mem_entry = '{map: mem_map, val: mem_val, tag: mem_instr_num};
  assign head      = fifo_q[rd_ptr_q];
  assign alu_ok    = alu_valid && (alu_map != '0);
  assign mem_ok    = mem_valid && (mem_map != '0);
  assign pop       = (count_q != '0) && !STALL;

`ifdef WB_BYPASS_EN
  assign byp = (count_q == '0) && !STALL && (alu_ok != mem_ok);
`else
  assign byp = 1'b0;
`endif

  // Occupancy after this edge's pop; mem claims space before alu so alu is the one dropped.
  assign occ     = {1'b0, count_q} - (CW+1)'(pop);
  assign mem_acc = mem_ok && !byp && (occ < DEPTH_X);
  assign alu_acc = alu_ok && !byp && ((occ + (CW+1)'(mem_acc)) < DEPTH_X);
  assign drop    = (mem_ok && !byp && !mem_acc) || (alu_ok && !byp && !alu_acc);

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    bc_d     = bc_q;
    bc_vld_d = 1'b0;
    busy_d   = busy_q;
    full_d   = full_q;
    ovf_d    = ovf_q;

    if (FLUSH) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      busy_d   = '1;
      full_d   = 1'b0;
    end else begin
      if (pop) begin
        bc_d             = head;
        bc_vld_d         = 1'b1;
        rd_ptr_d         = rd_ptr_q + PW'(1);
        busy_d[head.map] = 1'b1;
      end else if (byp) begin
        bc_d     = alu_ok ? alu_entry : mem_entry;
        bc_vld_d = 1'b1;
        busy_d[alu_ok ? alu_map : mem_map] = 1'b1;
      end

      if (mem_acc) fifo_d[wr_ptr_q] = mem_entry;
      if (alu_acc) fifo_d[wr_ptr_q + PW'(mem_acc)] = alu_entry;
      wr_ptr_d = wr_ptr_q + PW'(mem_acc) + PW'(alu_acc);
      count_d  = count_q - CW'(pop) + CW'(mem_acc) + CW'(alu_acc);

      // Allocation clear is applied last so it wins over a same-edge broadcast.
      if (rename_alloc && (rename_alloc_map != '0)) busy_d[rename_alloc_map] = 1'b0;
      if (drop) ovf_d = 1'b1;
      full_d = (count_d >= CW'(DEPTH - 1));
    end
    busy_d[0] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fifo_q   <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      bc_q     <= '0;
      bc_vld_q <= 1'b0;
      busy_q   <= '1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      bc_q     <= bc_d;
      bc_vld_q <= bc_vld_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign exe_broadcast       = bc_vld_q;
  assign exe_broadcast_map   = bc_q.map;
  assign exe_broadcast_val   = bc_q.val;
  assign broadcast_instr_num = bc_q.tag;
  assign busy                = busy_q;
  assign wb_full             = full_q;
  assign wb_overflow         = ovf_q;

endmodule
